// File: rtl/addr_trans_pipe.sv
// addr_trans_pipe
//   Pipelined virtual-to-physical address translation stage. A request is
//   translated by (in priority order) direct mode, the DMW windows, or the
//   micro-TLB. A uTLB miss walks the main TLB through a single-outstanding
//   lookup port and refills the uTLB on a successful lookup.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   da, pg, plv, mat_csr  : CRMD mode bits, sampled in the accept cycle
//   dmw                   : NUM_DMW packed DMW CSRs, window i at [32*i+31:32*i]
//   utlb_flush            : clears every uTLB valid bit at the next edge
//   req_*                 : request channel (valid/ready)
//   resp_*                : response channel (valid/ready) with result flags
//   tlb_req_*, tlb_resp_* : main TLB lookup port used while walking
//   dbg_state             : current FSM state (0 = IDLE, 1 = WALK)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready may depend on the state but never on the partner's valid.
module addr_trans_pipe #(
  parameter int NUM_DMW      = 2,
  parameter int UTLB_ENTRIES = 4,
  parameter int EN_TLB       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   da,
  input  logic                   pg,
  input  logic [1:0]             plv,
  input  logic [1:0]             mat_csr,
  input  logic [NUM_DMW*32-1:0]  dmw,
  input  logic                   utlb_flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_vaddr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_paddr,
  output logic [1:0]             resp_mat,
  output logic                   resp_is_dmw,
  output logic                   resp_is_tlb,
  output logic                   resp_miss,
  output logic                   tlb_req_valid,
  output logic [19:0]            tlb_req_vpn,
  input  logic                   tlb_resp_valid,
  input  logic                   tlb_resp_found,
  input  logic [19:0]            tlb_resp_pfn,
  input  logic [1:0]             tlb_resp_mat,
  output logic                   dbg_state
);

  localparam int IDX_W = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1;

  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} state_e;

  state_e state_q, state_d;

  // Response registers
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_paddr_q, resp_paddr_d;
  logic [1:0]  resp_mat_q,   resp_mat_d;
  logic        resp_dmw_q,   resp_dmw_d;
  logic        resp_tlb_q,   resp_tlb_d;
  logic        resp_miss_q,  resp_miss_d;

  // Walk context: VA and mat_csr captured at acceptance
  logic [31:0] walk_va_q,  walk_va_d;
  logic [1:0]  walk_mat_q, walk_mat_d;

  // uTLB storage
  logic [UTLB_ENTRIES-1:0] utlb_v_q;
  logic [19:0]             utlb_vpn_q [UTLB_ENTRIES];
  logic [19:0]             utlb_pfn_q [UTLB_ENTRIES];
  logic [1:0]              utlb_mat_q [UTLB_ENTRIES];
  logic [IDX_W-1:0]        rr_q;

  logic accept;
  logic fill_en;

  assign req_ready = (state_q == IDLE) && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  // ---------------- DMW lookup ----------------
  logic        dmw_hit;
  logic [31:0] dmw_pa;
  logic [1:0]  dmw_mat;
  logic [31:0] win;

  // Scanned from the highest index down so the lowest hitting window is
  // the last assignment and therefore wins.
  always_comb begin
    dmw_hit = 1'b0;
    dmw_pa  = 32'd0;
    dmw_mat = 2'd0;
    win     = 32'd0;
    for (int i = NUM_DMW - 1; i >= 0; i--) begin
      win = dmw[32*i +: 32];
      if (win[31:29] == req_vaddr[31:29] && win[plv]) begin
        dmw_hit = 1'b1;
        dmw_pa  = {win[27:25], req_vaddr[28:0]};
        dmw_mat = win[5:4];
      end
    end
  end

  // ---------------- uTLB lookup ----------------
  logic        utlb_hit;
  logic [19:0] utlb_pfn;
  logic [1:0]  utlb_mat;

  // Entries never share a VPN, so at most one can match.
  always_comb begin
    utlb_hit = 1'b0;
    utlb_pfn = 20'd0;
    utlb_mat = 2'd0;
    for (int i = 0; i < UTLB_ENTRIES; i++) begin
      if (utlb_v_q[i] && utlb_vpn_q[i] == req_vaddr[31:12]) begin
        utlb_hit = 1'b1;
        utlb_pfn = utlb_pfn_q[i];
        utlb_mat = utlb_mat_q[i];
      end
    end
  end

  // ---------------- combined lookup result ----------------
  logic [31:0] lk_pa;
  logic [1:0]  lk_mat;
  logic        lk_dmw, lk_tlb, lk_walk;

  always_comb begin
    lk_pa   = req_vaddr;
    lk_mat  = mat_csr;
    lk_dmw  = 1'b0;
    lk_tlb  = 1'b0;
    lk_walk = 1'b0;
    if (da && !pg) begin
      lk_pa  = req_vaddr;
    end else if (dmw_hit) begin
      lk_pa  = dmw_pa;
      lk_mat = dmw_mat;
      lk_dmw = 1'b1;
    end else if (EN_TLB != 0) begin
      if (utlb_hit) begin
        lk_pa  = {utlb_pfn, req_vaddr[11:0]};
        lk_mat = utlb_mat;
        lk_tlb = 1'b1;
      end else begin
        lk_walk = 1'b1;
      end
    end
  end

  // ---------------- victim selection ----------------
  logic             inv_found;
  logic [IDX_W-1:0] victim;

  always_comb begin
    inv_found = 1'b0;
    victim    = rr_q;
    for (int i = UTLB_ENTRIES - 1; i >= 0; i--) begin
      if (!utlb_v_q[i]) begin
        inv_found = 1'b1;
        victim    = IDX_W'(i);
      end
    end
  end

  // ---------------- FSM next state / response ----------------
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q && !resp_ready;
    resp_paddr_d = resp_paddr_q;
    resp_mat_d   = resp_mat_q;
    resp_dmw_d   = resp_dmw_q;
    resp_tlb_d   = resp_tlb_q;
    resp_miss_d  = resp_miss_q;
    walk_va_d    = walk_va_q;
    walk_mat_d   = walk_mat_q;
    fill_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (lk_walk) begin
            state_d    = WALK;
            walk_va_d  = req_vaddr;
            walk_mat_d = mat_csr;
          end else begin
            resp_valid_d = 1'b1;
            resp_paddr_d = lk_pa;
            resp_mat_d   = lk_mat;
            resp_dmw_d   = lk_dmw;
            resp_tlb_d   = lk_tlb;
            resp_miss_d  = 1'b0;
          end
        end
      end
      WALK: begin
        // The response slot is empty here: entering WALK required it to be
        // empty or draining on the accept edge, and a miss loads nothing.
        if (tlb_resp_valid) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_dmw_d   = 1'b0;
          resp_tlb_d   = 1'b1;
          if (tlb_resp_found) begin
            resp_paddr_d = {tlb_resp_pfn, walk_va_q[11:0]};
            resp_mat_d   = tlb_resp_mat;
            resp_miss_d  = 1'b0;
            fill_en      = 1'b1;
          end else begin
            resp_paddr_d = walk_va_q;
            resp_mat_d   = walk_mat_q;
            resp_miss_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= 32'd0;
      resp_mat_q   <= 2'd0;
      resp_dmw_q   <= 1'b0;
      resp_tlb_q   <= 1'b0;
      resp_miss_q  <= 1'b0;
      walk_va_q    <= 32'd0;
      walk_mat_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_paddr_q <= resp_paddr_d;
      resp_mat_q   <= resp_mat_d;
      resp_dmw_q   <= resp_dmw_d;
      resp_tlb_q   <= resp_tlb_d;
      resp_miss_q  <= resp_miss_d;
      walk_va_q    <= walk_va_d;
      walk_mat_q   <= walk_mat_d;
    end
  end

  // uTLB update: flush beats a same-cycle fill and leaves the pointer alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      utlb_v_q <= '0;
      rr_q     <= '0;
      for (int i = 0; i < UTLB_ENTRIES; i++) begin
        utlb_vpn_q[i] <= 20'd0;
        utlb_pfn_q[i] <= 20'd0;
        utlb_mat_q[i] <= 2'd0;
      end
    end else if (utlb_flush) begin
      utlb_v_q <= '0;
    end else if (fill_en) begin
      utlb_v_q[victim]   <= 1'b1;
      utlb_vpn_q[victim] <= walk_va_q[31:12];
      utlb_pfn_q[victim] <= tlb_resp_pfn;
      utlb_mat_q[victim] <= tlb_resp_mat;
      if (!inv_found) begin
        rr_q <= rr_q + 1'b1;
      end
    end
  end

  // Only the window tag, PLV enables, MAT and PSEG fields of each DMW matter.
  logic dmw_unused;
  assign dmw_unused = ^dmw;

  assign resp_valid    = resp_valid_q;
  assign resp_paddr    = resp_paddr_q;
  assign resp_mat      = resp_mat_q;
  assign resp_is_dmw   = resp_dmw_q;
  assign resp_is_tlb   = resp_tlb_q;
  assign resp_miss     = resp_miss_q;
  assign tlb_req_valid = (state_q == WALK);
  assign tlb_req_vpn   = walk_va_q[31:12];
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_addr_trans_pipe.sv
module tb_addr_trans_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        da, pg;
  logic [1:0]  plv, mat_csr;
  logic [63:0] dmw;
  logic        utlb_flush;
  logic        req_valid, req_ready;
  logic [31:0] req_vaddr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_paddr;
  logic [1:0]  resp_mat;
  logic        resp_is_dmw, resp_is_tlb, resp_miss;
  logic        tlb_req_valid;
  logic [19:0] tlb_req_vpn;
  logic        tlb_resp_valid, tlb_resp_found;
  logic [19:0] tlb_resp_pfn;
  logic [1:0]  tlb_resp_mat;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addr_trans_pipe #(.NUM_DMW(2), .UTLB_ENTRIES(4), .EN_TLB(1)) dut (
    .clk(clk), .reset(reset), .da(da), .pg(pg), .plv(plv), .mat_csr(mat_csr),
    .dmw(dmw), .utlb_flush(utlb_flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_mat(resp_mat), .resp_is_dmw(resp_is_dmw), .resp_is_tlb(resp_is_tlb),
    .resp_miss(resp_miss), .tlb_req_valid(tlb_req_valid), .tlb_req_vpn(tlb_req_vpn),
    .tlb_resp_valid(tlb_resp_valid), .tlb_resp_found(tlb_resp_found),
    .tlb_resp_pfn(tlb_resp_pfn), .tlb_resp_mat(tlb_resp_mat), .dbg_state(dbg_state)
  );

  // ---------------- clock/reset and driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted; returns 1 ns after the accept edge.
  task automatic send(input logic [31:0] va);
    int n;
    req_vaddr = va;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 40) begin
      tick;
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout va=%h req_ready=%b required=1", va, req_ready);
    end else begin
      tick;
    end
    req_valid = 1'b0;
  endtask

  // Drive one main-TLB response after dly extra WALK cycles.
  task automatic tlb_respond(input int dly, input logic found, input logic [19:0] pfn,
                             input logic [1:0] mat, input logic flush);
    repeat (dly) tick;
    tlb_resp_valid = 1'b1;
    tlb_resp_found = found;
    tlb_resp_pfn   = pfn;
    tlb_resp_mat   = mat;
    utlb_flush     = flush;
    tick;
    tlb_resp_valid = 1'b0;
    tlb_resp_found = 1'b0;
    utlb_flush     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    total++;
    if (resp_valid !== 1'b0 || resp_paddr !== 32'd0 || resp_mat !== 2'd0) begin
      bad++;
      $display("FAIL reset_resp got v=%b pa=%h mat=%0d required v=0 pa=0 mat=0",
               resp_valid, resp_paddr, resp_mat);
    end
    total++;
    if (resp_is_dmw !== 1'b0 || resp_is_tlb !== 1'b0 || resp_miss !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got dmw=%b tlb=%b miss=%b required 0 0 0",
               resp_is_dmw, resp_is_tlb, resp_miss);
    end
    total++;
    if (tlb_req_valid !== 1'b0 || tlb_req_vpn !== 20'd0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_tlbreq got tv=%b vpn=%h rdy=%b required 0 0 1",
               tlb_req_valid, tlb_req_vpn, req_ready);
    end
  endtask

  task automatic test_direct;
    da = 1'b1; pg = 1'b0; mat_csr = 2'd1;
    send(32'h1C00_0000);
    total++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h1C00_0000 || resp_mat !== 2'd1) begin
      bad++;
      $display("FAIL direct got v=%b pa=%h mat=%0d required 1 1c000000 1",
               resp_valid, resp_paddr, resp_mat);
    end
    total++;
    if (resp_is_dmw !== 1'b0 || resp_is_tlb !== 1'b0 || resp_miss !== 1'b0) begin
      bad++;
      $display("FAIL direct_flags got dmw=%b tlb=%b miss=%b required 0 0 0",
               resp_is_dmw, resp_is_tlb, resp_miss);
    end
    tick;
  endtask

  task automatic test_dmw;
    da = 1'b0; pg = 1'b1; plv = 2'd0; mat_csr = 2'd0;
    dmw = {32'hA000_0001, 32'hA000_0011};
    send(32'hA000_1234);
    total++;
    if (resp_paddr !== 32'h0000_1234 || resp_mat !== 2'd1 || resp_is_dmw !== 1'b1 ||
        resp_is_tlb !== 1'b0) begin
      bad++;
      $display("FAIL dmw_prio got pa=%h mat=%0d dmw=%b tlb=%b required 00001234 1 1 0",
               resp_paddr, resp_mat, resp_is_dmw, resp_is_tlb);
    end
    tick;
    // plv 3 is disabled in window 0, enabled in window 1
    plv = 2'd3;
    dmw = {32'h8A00_0028, 32'hA000_0011};
    send(32'h8000_0ABC);
    total++;
    if (resp_paddr !== 32'hA000_0ABC || resp_mat !== 2'd2 || resp_is_dmw !== 1'b1) begin
      bad++;
      $display("FAIL dmw_win1 got pa=%h mat=%0d dmw=%b required a0000abc 2 1",
               resp_paddr, resp_mat, resp_is_dmw);
    end
    tick;
    plv = 2'd0;
    dmw = 64'd0;
  endtask

  task automatic test_miss_hit;
    mat_csr = 2'd0;
    send(32'h0040_0ABC);
    total++;
    if (tlb_req_valid !== 1'b1 || tlb_req_vpn !== 20'h00400 || req_ready !== 1'b0 ||
        resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL miss_walk got tv=%b vpn=%h rdy=%b rv=%b required 1 00400 0 0",
               tlb_req_valid, tlb_req_vpn, req_ready, resp_valid);
    end
    tlb_respond(2, 1'b1, 20'h12345, 2'd1, 1'b0);
    total++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h1234_5ABC || resp_mat !== 2'd1 ||
        resp_is_tlb !== 1'b1 || resp_miss !== 1'b0 || tlb_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL miss_fill got v=%b pa=%h mat=%0d tlb=%b miss=%b tv=%b required 1 12345abc 1 1 0 0",
               resp_valid, resp_paddr, resp_mat, resp_is_tlb, resp_miss, tlb_req_valid);
    end
    tick;
    send(32'h0040_0123);
    total++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h1234_5123 || tlb_req_valid !== 1'b0 ||
        resp_is_tlb !== 1'b1) begin
      bad++;
      $display("FAIL utlb_hit got v=%b pa=%h tv=%b tlb=%b required 1 12345123 0 1",
               resp_valid, resp_paddr, tlb_req_valid, resp_is_tlb);
    end
    tick;
  endtask

  task automatic test_not_found;
    mat_csr = 2'd2;
    send(32'h0077_7456);
    mat_csr = 2'd3;   // must not affect the walk in flight
    tlb_respond(0, 1'b0, 20'hFFFFF, 2'd3, 1'b0);
    total++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h0077_7456 || resp_mat !== 2'd2 ||
        resp_miss !== 1'b1 || resp_is_tlb !== 1'b1 || resp_is_dmw !== 1'b0) begin
      bad++;
      $display("FAIL not_found got v=%b pa=%h mat=%0d miss=%b tlb=%b dmw=%b required 1 00777456 2 1 1 0",
               resp_valid, resp_paddr, resp_mat, resp_miss, resp_is_tlb, resp_is_dmw);
    end
    tick;
    send(32'h0077_7000);
    total++;
    if (tlb_req_valid !== 1'b1 || tlb_req_vpn !== 20'h00777) begin
      bad++;
      $display("FAIL not_found_rewalk got tv=%b vpn=%h required 1 00777", tlb_req_valid, tlb_req_vpn);
    end
    tlb_respond(0, 1'b0, 20'd0, 2'd0, 1'b0);
    tick;
    mat_csr = 2'd0;
  endtask

  task automatic test_replacement;
    utlb_flush = 1'b1;
    tick;
    utlb_flush = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send({20'h10000 + 20'(k), 12'h000});
      total++;
      if (tlb_req_valid !== 1'b1) begin
        bad++;
        $display("FAIL fill_miss_%0d got tv=%b required 1", k, tlb_req_valid);
      end
      tlb_respond(0, 1'b1, 20'h20000 + 20'(k), 2'd1, 1'b0);
      tick;
    end
    // Entry 0 (VPN 0x10001) was evicted by the 5th fill
    send(32'h1000_1000);
    total++;
    if (tlb_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL evict_vpn1 got tv=%b required 1", tlb_req_valid);
    end
    tlb_respond(1, 1'b1, 20'h20011, 2'd1, 1'b0);  // evicts entry 1 (VPN 0x10002)
    tick;
    send(32'h1000_5ABC);
    total++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h2000_5ABC || tlb_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL hit_vpn5 got v=%b pa=%h tv=%b required 1 20005abc 0",
               resp_valid, resp_paddr, tlb_req_valid);
    end
    tick;
    send(32'h1000_1010);
    total++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h2001_1010 || tlb_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL hit_vpn1 got v=%b pa=%h tv=%b required 1 20011010 0",
               resp_valid, resp_paddr, tlb_req_valid);
    end
    tick;
    send(32'h1000_2000);
    total++;
    if (tlb_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL rr_evict_vpn2 got tv=%b required 1", tlb_req_valid);
    end
    tlb_respond(0, 1'b1, 20'h20002, 2'd1, 1'b0);
    tick;
  endtask

  task automatic test_flush_fill;
    send(32'h3000_0000);
    tlb_respond(0, 1'b1, 20'h40000, 2'd2, 1'b1);
    total++;
    if (resp_valid !== 1'b1 || resp_paddr !== 32'h4000_0000 || resp_mat !== 2'd2) begin
      bad++;
      $display("FAIL flush_fill_resp got v=%b pa=%h mat=%0d required 1 40000000 2",
               resp_valid, resp_paddr, resp_mat);
    end
    tick;
    send(32'h3000_0004);
    total++;
    if (tlb_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_fill_nofill got tv=%b required 1", tlb_req_valid);
    end
    tlb_respond(0, 1'b1, 20'h40000, 2'd2, 1'b0);
    tick;
  endtask

  task automatic test_back_to_back;
    da = 1'b1; pg = 1'b0; mat_csr = 2'd3;
    resp_ready = 1'b0;
    send(32'h0000_0100);
    req_valid = 1'b1;
    req_vaddr = 32'h0000_0999;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_paddr !== 32'h0000_0100 || resp_mat !== 2'd3 ||
          req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d got v=%b pa=%h mat=%0d rdy=%b required 1 00000100 3 0",
                 k, resp_valid, resp_paddr, resp_mat, req_ready);
      end
      tick;
    end
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_vaddr = 32'h0000_2000 + 32'(k * 16);
      #1;
      total++;
      if (req_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready_%0d got %b required 1", k, req_ready);
      end
      tick;
      total++;
      if (resp_valid !== 1'b1 || resp_paddr !== 32'h0000_2000 + 32'(k * 16)) begin
        bad++;
        $display("FAIL b2b_resp_%0d got v=%b pa=%h required 1 %h",
                 k, resp_valid, resp_paddr, 32'h0000_2000 + 32'(k * 16));
      end
    end
    req_valid = 1'b0;
    tick;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got v=%b required 0", resp_valid);
    end
  endtask

  task automatic test_reset_walk;
    da = 1'b0; pg = 1'b1; mat_csr = 2'd0;
    send(32'h0055_5000);
    total++;
    if (tlb_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstwalk_enter got tv=%b required 1", tlb_req_valid);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++;
    if (tlb_req_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstwalk_abort got tv=%b rv=%b rdy=%b required 0 0 1",
               tlb_req_valid, resp_valid, req_ready);
    end
    tlb_respond(0, 1'b1, 20'h55555, 2'd1, 1'b0);
    total++;
    if (resp_valid !== 1'b0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL rstwalk_late got rv=%b st=%b required 0 0", resp_valid, dbg_state);
    end
    // uTLB was cleared by reset: a formerly cached VPN walks again
    send(32'h1000_5000);
    total++;
    if (tlb_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstwalk_utlb_clear got tv=%b required 1", tlb_req_valid);
    end
    tlb_respond(0, 1'b0, 20'd0, 2'd0, 1'b0);
    tick;
  endtask

  initial begin
    reset = 1'b1; da = 1'b0; pg = 1'b0; plv = 2'd0; mat_csr = 2'd0; dmw = 64'd0;
    utlb_flush = 1'b0; req_valid = 1'b0; req_vaddr = 32'd0; resp_ready = 1'b1;
    tlb_resp_valid = 1'b0; tlb_resp_found = 1'b0; tlb_resp_pfn = 20'd0; tlb_resp_mat = 2'd0;
    test_reset;
    test_direct;
    test_dmw;
    test_miss_hit;
    test_not_found;
    test_replacement;
    test_flush_fill;
    test_back_to_back;
    test_reset_walk;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
